// File: rtl/run_seq_pkg.sv
// Shared state encoding and default configuration for the CPU run sequencer.
package run_seq_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD_RESET = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } run_state_t;

  localparam int          DEF_WIDTH        = 16;
  localparam int          DEF_RESET_CYCLES = 5;
  localparam int          DEF_RUN_CYCLES   = 41;
  localparam int          DEF_TRACE_DEPTH  = 8;
  localparam bit          DEF_HALT_EN      = 1'b0;
  localparam logic [15:0] DEF_HALT_VALUE   = 16'hFFFF;

endpackage

// File: rtl/trace_fifo.sv
// Power-of-two trace FIFO; head is presented combinationally from registered storage.
module trace_fifo #(
  parameter int WIDTH       = 16,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(TRACE_DEPTH):0]   count
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [TRACE_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  always_comb begin
    do_push = push && (!full || pop);
    do_pop  = pop && !empty;
  end

  assign full    = (count == CW'(TRACE_DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cpu_run_sequencer.sv
// Drives a CPU through reset and a bounded run window while tracing changes on its output bus.
module cpu_run_sequencer
  import run_seq_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter int               RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int               RUN_CYCLES   = DEF_RUN_CYCLES,
  parameter int               TRACE_DEPTH  = DEF_TRACE_DEPTH,
  parameter bit               HALT_EN      = DEF_HALT_EN,
  parameter logic [WIDTH-1:0] HALT_VALUE   = WIDTH'(DEF_HALT_VALUE)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [WIDTH-1:0]                  program_out,
  output logic                              dut_reset,
  output logic                              dut_run,
  output logic [WIDTH-1:0]                  trace_data,
  output logic                              trace_valid,
  input  logic                              trace_ready,
  output logic                              overflow,
  output logic                              halted,
  output logic                              done,
  output logic [$clog2(RUN_CYCLES+1)-1:0]   run_count
);

  localparam int RC_W    = $clog2(RUN_CYCLES + 1);
  localparam int CNT_MAX = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  run_state_t                 state;
  logic [CNT_W-1:0]           cnt;
  logic [WIDTH-1:0]           last_pushed;
  logic                       halt_hit;
  logic                       push;
  logic                       pop;
  logic                       fifo_clear;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(TRACE_DEPTH):0] fifo_count_unused;

  // run_count is zero only on the first RUN cycle, which always pushes.
  always_comb begin
    halt_hit   = HALT_EN && (program_out == HALT_VALUE);
    push       = (state == RUN) && ((run_count == '0) || (program_out != last_pushed));
    pop        = !fifo_empty && trace_ready;
    fifo_clear = ((state == IDLE) || (state == DONE)) && start;
  end

  assign trace_valid = !fifo_empty;

  trace_fifo #(
    .WIDTH       (WIDTH),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clock   (clock),
    .reset   (reset),
    .clear   (fifo_clear),
    .push    (push),
    .pop     (pop),
    .wr_data (program_out),
    .rd_data (trace_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

  // One down-counter times both the CPU reset hold and the run window.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dut_reset <= 1'b0;
      dut_run   <= 1'b0;
      done      <= 1'b0;
      halted    <= 1'b0;
      overflow  <= 1'b0;
      run_count <= '0;
    end else begin
      if (push && fifo_full && !pop) overflow <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= HOLD_RESET;
            cnt       <= CNT_W'(RESET_CYCLES - 1);
            dut_reset <= 1'b1;
            done      <= 1'b0;
            halted    <= 1'b0;
            overflow  <= 1'b0;
            run_count <= '0;
          end
        end
        HOLD_RESET: begin
          if (cnt == '0) begin
            state     <= RUN;
            cnt       <= CNT_W'(RUN_CYCLES - 1);
            dut_reset <= 1'b0;
            dut_run   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RUN: begin
          run_count <= run_count + RC_W'(1);
          if ((cnt == '0) || halt_hit) begin
            state   <= DONE;
            dut_run <= 1'b0;
            done    <= 1'b1;
            halted  <= halt_hit;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) last_pushed <= program_out;
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed and randomized checks of cpu_run_sequencer against a queue-based reference model.
module tb_cpu_run_sequencer;

  localparam int          W  = 16;
  localparam int          RC = 5;
  localparam int          RN = 41;
  localparam int          D  = 8;
  localparam logic [15:0] HV = 16'hFFFF;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  program_out;
  logic          dut_reset;
  logic          dut_run;
  logic [W-1:0]  trace_data;
  logic          trace_valid;
  logic          trace_ready;
  logic          overflow;
  logic          halted;
  logic          done;
  logic [5:0]    run_count;

  always #5 clock = ~clock;

  cpu_run_sequencer #(
    .WIDTH        (W),
    .RESET_CYCLES (RC),
    .RUN_CYCLES   (RN),
    .TRACE_DEPTH  (D),
    .HALT_EN      (1'b1),
    .HALT_VALUE   (HV)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .program_out (program_out),
    .dut_reset   (dut_reset),
    .dut_run     (dut_run),
    .trace_data  (trace_data),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .overflow    (overflow),
    .halted      (halted),
    .done        (done),
    .run_count   (run_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 holding CPU reset, 2 running, 3 finished.
  int          m_ph   = 0;
  int          m_t    = 0;
  int          m_rc   = 0;
  bit          m_ovf  = 1'b0;
  bit          m_halt = 1'b0;
  logic [15:0] m_last = '0;
  logic [15:0] m_q[$];

  logic [15:0] pat[64];
  int          pat_len = 1;
  bit          use_pat = 1'b0;
  logic [15:0] got[32];
  int          ngot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit pop;
    bit push;
    pop = (m_q.size() > 0) && trace_ready;
    if (reset) begin
      m_ph = 0; m_t = 0; m_rc = 0; m_ovf = 0; m_halt = 0;
      m_q.delete();
    end else begin
      case (m_ph)
        0, 3: if (start) begin
          m_ph = 1; m_t = 0; m_rc = 0; m_ovf = 0; m_halt = 0;
          m_q.delete();
          pop = 0;
        end
        1: begin
          m_t++;
          if (m_t == RC) m_ph = 2;
        end
        2: begin
          push = (m_rc == 0) || (program_out != m_last);
          if (pop) begin
            void'(m_q.pop_front());
            pop = 0;
          end
          if (push) begin
            m_last = program_out;
            if (m_q.size() < D) m_q.push_back(program_out);
            else m_ovf = 1;
          end
          m_rc++;
          if (m_rc == RN || program_out == HV) begin
            m_ph   = 3;
            m_halt = (program_out == HV);
          end
        end
        default: ;
      endcase
      if (pop) void'(m_q.pop_front());
    end
  endtask

  task automatic check_all();
    chk("dut_reset",   dut_reset,   m_ph == 1);
    chk("dut_run",     dut_run,     m_ph == 2);
    chk("done",        done,        m_ph == 3);
    chk("overflow",    overflow,    m_ovf);
    chk("halted",      halted,      m_halt);
    chk("run_count",   run_count,   m_rc);
    chk("trace_valid", trace_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("trace_data", trace_data, m_q[0]);
  endtask

  task automatic tick();
    if (use_pat && m_ph == 2)
      program_out = (m_rc < pat_len) ? pat[m_rc] : pat[pat_len-1];
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic drain();
    trace_ready = 1'b1;
    ngot = 0;
    for (int i = 0; i < 20; i++) begin
      if (!trace_valid) break;
      got[ngot] = trace_data;
      ngot++;
      tick();
    end
    trace_ready = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic full_run(input string tag);
    int nr;
    int nd;
    nr = 0;
    nd = 0;
    start = 1'b1;
    for (int i = 0; i < 80 && !done; i++) begin
      tick();
      start = 1'b0;
      nr += int'(dut_reset);
      nd += int'(dut_run);
    end
    chk({tag, "_reset_len"}, nr, RC);
    chk({tag, "_run_len"},   nd, RN);
    chk({tag, "_done"},      done, 1);
    chk({tag, "_run_count"}, run_count, RN);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; trace_ready = 1'b0; program_out = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_idle_run", dut_run, 0);
    chk("reset_idle_done", done, 0);

    // Default-length run with a constant bus value.
    program_out = 16'h0005;
    full_run("basic");
    drain();
    chk("basic_entries", ngot, 1);

    // Repeated values collapse into single trace entries.
    pat[0] = 1; pat[1] = 1; pat[2] = 2; pat[3] = 2; pat[4] = 3;
    pat_len = 5; use_pat = 1'b1;
    pulse_start();
    wait_done("dedup", 80);
    drain();
    chk("dedup_entries", ngot, 3);
    chk("dedup_e0", got[0], 1);
    chk("dedup_e1", got[1], 2);
    chk("dedup_e2", got[2], 3);

    // More distinct values than FIFO slots: the oldest ones survive.
    for (int i = 0; i < 10; i++) pat[i] = 16'(i + 1);
    pat_len = 10;
    pulse_start();
    wait_done("ovf", 80);
    chk("ovf_flag", overflow, 1);
    drain();
    chk("ovf_entries", ngot, D);
    for (int i = 0; i < D; i++) chk("ovf_order", got[i], i + 1);
    pulse_start();
    chk("ovf_cleared", overflow, 0);
    wait_done("ovf_rerun", 80);
    drain();

    // Halt value on the tenth run cycle ends the run early.
    for (int i = 0; i < 9; i++) pat[i] = 16'(20 + i);
    pat[9] = HV; pat[10] = 16'h0030; pat_len = 11;
    pulse_start();
    wait_done("halt", 80);
    chk("halt_flag", halted, 1);
    chk("halt_run_count", run_count, 10);
    drain();
    chk("halt_entries", ngot, D);

    // Reset in the seventh run cycle aborts the run.
    for (int i = 0; i < 10; i++) pat[i] = 16'(40 + i);
    pat_len = 10;
    pulse_start();
    for (int i = 0; i < 40 && !(m_ph == 2 && m_rc == 6); i++) tick();
    chk("abort_reached", run_count, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_dut_run", dut_run, 0);
    chk("abort_dut_reset", dut_reset, 0);
    chk("abort_done", done, 0);
    chk("abort_run_count", run_count, 0);
    chk("abort_valid", trace_valid, 0);
    use_pat = 1'b0;
    program_out = 16'h0077;
    full_run("after_abort");
    drain();

    // Push and pop together on a full FIFO.
    for (int i = 0; i < 9; i++) pat[i] = 16'(i + 1);
    pat_len = 9; use_pat = 1'b1;
    pulse_start();
    for (int i = 0; i < 40 && !(m_ph == 2 && m_rc == 8); i++) tick();
    chk("fullpp_valid", trace_valid, 1);
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    chk("fullpp_ovf", overflow, 0);
    wait_done("fullpp", 80);
    chk("fullpp_ovf_end", overflow, 0);
    drain();
    chk("fullpp_entries", ngot, D);
    for (int i = 0; i < D; i++) chk("fullpp_order", got[i], i + 2);

    // Randomized traffic, including ignored starts and occasional resets.
    use_pat = 1'b0;
    for (int i = 0; i < 600; i++) begin
      program_out = ($urandom_range(0, 29) == 0) ? HV : 16'($urandom_range(1, 3));
      trace_ready = 1'($urandom_range(0, 1));
      start       = ($urandom_range(0, 11) == 0);
      reset       = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0; trace_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_sequencer.md
CPU_RUN_SEQUENCER -- requirements
Module: cpu_run_sequencer

Interface
REQ-001 Parameter WIDTH, 16, width of the monitored program_out bus.
REQ-002 Parameter RESET_CYCLES, 5, cycles dut_reset is held high per run; legal range ≥1.
REQ-003 Parameter RUN_CYCLES, 41, maximum cycles dut_run is held high per run; legal range ≥1.
REQ-004 Parameter TRACE_DEPTH, 8, trace FIFO entries; legal values are powers of 2, ≥2.
REQ-005 Parameter HALT_EN, 0, when 1, a match against HALT_VALUE ends the run early.
REQ-006 Parameter HALT_VALUE, 16'hFFFF, program_out value that signals a CPU halt (WIDTH bits).
REQ-007 Port clock  in  1  single clock; all state changes occur on its rising edge.
REQ-008 Port reset  in  1  synchronous, active-high reset.
REQ-009 Port start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
REQ-010 Port program_out  in  WIDTH  CPU output bus under observation.
REQ-011 Port dut_reset  out  1  reset driven to the CPU.
REQ-012 Port dut_run  out  1  clock-enable driven to the CPU.
REQ-013 Port trace_data  out  WIDTH  oldest unread trace entry.
REQ-014 Port trace_valid  out  1  trace FIFO is not empty.
REQ-015 Port trace_ready  in  1  consumer accepts trace_data.
REQ-016 Port overflow  out  1  sticky flag: at least one trace entry was dropped.
REQ-017 Port halted  out  1  the last run ended on a HALT_VALUE match.
REQ-018 Port done  out  1  sequencer is in the DONE state.
REQ-019 Port run_count  out  clog2(RUN_CYCLES+1)  number of RUN cycles in the current/last run.

Function
REQ-020 The FSM SHALL have four states, IDLE, HOLD_RESET, RUN and DONE, with IDLE as the reset state.
REQ-021 IDLE or DONE with start=1 SHALL move to HOLD_RESET on the next edge, clearing the trace FIFO, overflow, halted and run_count.
REQ-022 dut_reset SHALL be 1 in exactly the RESET_CYCLES consecutive cycles spent in HOLD_RESET and 0 in every other state.
REQ-023 After RESET_CYCLES cycles the FSM SHALL move from HOLD_RESET to RUN.
REQ-024 dut_run SHALL be 1 only in RUN, and run_count SHALL increment once per RUN cycle.
REQ-025 RUN SHALL move to DONE after RUN_CYCLES cycles or, when HALT_EN=1, after the first RUN cycle in which program_out==HALT_VALUE, whichever comes first.
REQ-026 On a halt match, halted SHALL be set to 1 in the same transition into DONE.
REQ-027 In DONE, done SHALL be 1 and dut_run 0; the FSM SHALL remain in DONE until start.
REQ-028 start SHALL be ignored in HOLD_RESET and RUN; a run cannot be aborted except by reset.
REQ-029 Trace push: in each RUN cycle, program_out SHALL be pushed if it is the first RUN cycle or it differs from the last pushed value.
REQ-030 A push when the FIFO is full and no pop occurs SHALL be dropped and SHALL set overflow until the next start or reset.
REQ-031 Pop SHALL occur when trace_valid && trace_ready; trace_data SHALL show the FIFO head combinationally from registered storage.
REQ-032 A simultaneous push and pop on a full FIFO SHALL accept both, leave the occupancy unchanged and not set overflow.
REQ-033 When the FIFO is empty, trace_valid SHALL be 0 and trace_data is don't-care.
REQ-034 Read and write pointers SHALL wrap modulo TRACE_DEPTH, with a separate occupancy count of clog2(TRACE_DEPTH)+1 bits.
REQ-035 The FIFO SHALL remain readable in DONE and IDLE until it is cleared by start.

Reset
REQ-036 reset=1 SHALL force IDLE on the next edge, from any state including mid-run.
REQ-037 After reset: dut_reset=0, dut_run=0, done=0, halted=0, overflow=0, run_count=0, FIFO empty (trace_valid=0).
REQ-038 reset SHALL take priority over start and over any trace push or pop in the same cycle.

Structure
REQ-039 Package run_seq_pkg SHALL hold the state encoding typedef and the default parameter constants.
REQ-040 The FIFO SHALL be the sub-module trace_fifo, parameterised by WIDTH and TRACE_DEPTH, with push, pop, clear, full, empty and count.
REQ-041 A single down-counter SHALL be reused for the HOLD_RESET and RUN durations.

Verification
REQ-042 Defaults, start pulse → dut_reset high exactly 5 cycles, then dut_run high exactly 41 cycles, done=1, run_count=41.
REQ-043 program_out sequence 1,1,2,2,3 during RUN, trace_ready=0 → exactly 3 entries read back as 1,2,3.
REQ-044 TRACE_DEPTH=2, 4 distinct values, trace_ready=0 → entries 1,2 retained, overflow=1; next start clears overflow.
REQ-045 HALT_EN=1, program_out=16'hFFFF on RUN cycle 10 → DONE after cycle 10, halted=1, run_count=10.
REQ-046 reset asserted on RUN cycle 7 → next cycle IDLE, all outputs at reset values, and a later start gives a full 5/41 run.
REQ-047 Full FIFO with a push and trace_ready=1 in the same cycle → count unchanged, overflow stays 0, order preserved.
